// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped full-duplex UART: TX/RX byte FIFOs, sticky status flags and a registered level interrupt.
// Both serial FSMs share one state encoding:
//   state | meaning
//   IDLE  | line idle; TX waits for a queued byte, RX waits for a falling edge
//   START | start bit; TX drives 0, RX waits half a bit and re-checks the line
//   DATA  | eight data bits, LSB first, one every CLK_DIV cycles
//   STOP  | stop bit; TX drives 1, RX samples it and pushes or flags frame_err

module mmio_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       rejected
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  // a full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_push  = push && (!full || do_pop);
  assign rejected = push && !do_push;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mmio_uart_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0020,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_DIV    = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  rx_pin_i,
  output logic                  tx_pin_o,
  output logic                  irq_o
);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  uart_state_t tx_state, tx_state_nxt, rx_state, rx_state_nxt;
  logic [TW-1:0] tx_tmr, tx_tmr_nxt, rx_tmr, rx_tmr_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt, rx_bit, rx_bit_nxt;
  logic [7:0]    tx_shr, tx_shr_nxt, rx_shr, rx_shr_nxt;
  logic          rx_s1, rx_s2, rx_s3;
  logic          tx_pop, rx_push, ferr_set;
  logic          tx_ovf, rx_ovf, frame_err, tx_ie, rx_ie, tx_busy;
  logic          tx_full, tx_empty, tx_rejected, rx_full, rx_empty, rx_rejected;
  logic [7:0]    tx_head, rx_head, status;
  logic          sel, tx_wr, ctrl_wr, rx_rd;
  logic [1:0]    off;
  logic          unused;

  assign sel     = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign off     = addr_i[3:2];
  assign tx_wr   = we_i && sel && (off == 2'd0);
  assign rx_rd   = re_i && sel && (off == 2'd1);
  assign ctrl_wr = we_i && sel && (off == 2'd3);
  assign unused  = ^{addr_i[1:0], wdata_i[DATA_WIDTH-1:8]};

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_wr), .pop(tx_pop), .din(wdata_i[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .rejected(tx_rejected)
  );

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_rd), .din(rx_shr),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .rejected(rx_rejected)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_tmr   <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      rx_state <= ST_IDLE;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_shr   <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tmr   <= tx_tmr_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shr   <= tx_shr_nxt;
      rx_state <= rx_state_nxt;
      rx_tmr   <= rx_tmr_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shr   <= rx_shr_nxt;
      rx_s1    <= rx_pin_i;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tmr_nxt   = tx_tmr;
    tx_bit_nxt   = tx_bit;
    tx_shr_nxt   = tx_shr;
    tx_pop       = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_shr_nxt   = tx_head;
          tx_tmr_nxt   = BIT_LAST;
          tx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tx_tmr != '0) tx_tmr_nxt = tx_tmr - 1'b1;
        else begin
          tx_tmr_nxt   = BIT_LAST;
          tx_bit_nxt   = 3'd0;
          tx_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tmr != '0) tx_tmr_nxt = tx_tmr - 1'b1;
        else begin
          tx_tmr_nxt = BIT_LAST;
          tx_shr_nxt = {1'b0, tx_shr[7:1]};
          if (tx_bit == 3'd7) tx_state_nxt = ST_STOP;
          else                tx_bit_nxt   = tx_bit + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_tmr != '0) tx_tmr_nxt = tx_tmr - 1'b1;
        else if (!tx_empty) begin
          // chain straight into the next frame so there is no idle gap
          tx_pop       = 1'b1;
          tx_shr_nxt   = tx_head;
          tx_tmr_nxt   = BIT_LAST;
          tx_state_nxt = ST_START;
        end else begin
          tx_state_nxt = ST_IDLE;
        end
      end
      default: tx_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tmr_nxt   = rx_tmr;
    rx_bit_nxt   = rx_bit;
    rx_shr_nxt   = rx_shr;
    rx_push      = 1'b0;
    ferr_set     = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_tmr_nxt   = HALF_LAST;
          rx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (rx_tmr != '0) rx_tmr_nxt = rx_tmr - 1'b1;
        else if (!rx_s2) begin
          rx_tmr_nxt   = BIT_LAST;
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = ST_DATA;
        end else begin
          rx_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_tmr != '0) rx_tmr_nxt = rx_tmr - 1'b1;
        else begin
          rx_tmr_nxt = BIT_LAST;
          rx_shr_nxt = {rx_s2, rx_shr[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = ST_STOP;
          else                rx_bit_nxt   = rx_bit + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_tmr != '0) rx_tmr_nxt = rx_tmr - 1'b1;
        else begin
          rx_state_nxt = ST_IDLE;
          if (rx_s2) rx_push  = 1'b1;
          else       ferr_set = 1'b1;
        end
      end
      default: rx_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_busy  = (tx_state != ST_IDLE);
  assign tx_pin_o = (tx_state == ST_START) ? 1'b0 :
                    (tx_state == ST_DATA)  ? tx_shr[0] : 1'b1;
  assign status   = {frame_err, rx_ovf, tx_ovf, tx_busy, rx_empty, rx_full, tx_empty, tx_full};

  // set terms are ORed after the W1C mask so a same-cycle event wins over the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      tx_ovf    <= tx_rejected | (tx_ovf    & ~(ctrl_wr & wdata_i[5]));
      rx_ovf    <= rx_rejected | (rx_ovf    & ~(ctrl_wr & wdata_i[6]));
      frame_err <= ferr_set    | (frame_err & ~(ctrl_wr & wdata_i[7]));
      if (ctrl_wr) begin
        tx_ie <= wdata_i[0];
        rx_ie <= wdata_i[1];
      end
      irq_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel) begin
      case (off)
        2'd1:    rdata_o[7:0] = rx_empty ? 8'h00 : rx_head;
        2'd2:    rdata_o[7:0] = status;
        2'd3:    rdata_o[7:0] = {6'b0, rx_ie, tx_ie};
        default: rdata_o = '0;
      endcase
    end
  end
endmodule
